// File: rtl/mux_2to1_pkg.sv
// ---------------------------------------------------------------------------
// Package: mux_2to1_pkg
// Purpose: shared constants and types for the registered 2-to-1 selector.
//   MUX_WIDTH_DEF - default data width of the selector
//   MUX_WIDTH_MAX - widest data path the selector is meant to be built with
//   mux_sel_e     - named encoding of the select value (in_0 / in_1)
// ---------------------------------------------------------------------------
package mux_2to1_pkg;

  localparam int MUX_WIDTH_DEF = 1;
  localparam int MUX_WIDTH_MAX = 64;

  typedef enum logic {
    SEL_IN0 = 1'b0,
    SEL_IN1 = 1'b1
  } mux_sel_e;

endpackage : mux_2to1_pkg

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// Module: sync_2ff
// Purpose: single-bit two-flop synchronizer; both stages clear to 0 on reset.
// Ports:
//   clk   in  1  rising-edge clock
//   rst_n in  1  asynchronous, active-low reset
//   d     in  1  asynchronous input bit
//   q     out 1  synchronized bit, two clock edges behind d
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // The first stage may go metastable; only the second stage is exposed.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff

// File: rtl/mux_2to1.sv
// ---------------------------------------------------------------------------
// Module: mux_2to1
// Purpose: registered 2-to-1 data selector. Forwards in_0 or in_1 to a
//   flop-driven out, reports the select value actually applied and pulses a
//   flag on every change of that applied select.
// Parameters:
//   WIDTH       data width, legal range 1..MUX_WIDTH_MAX (64)
// Ports:
//   clk         in  1      rising-edge clock
//   rst_n       in  1      asynchronous, active-low reset
//   in_0        in  WIDTH  data selected when applied select = 0
//   in_1        in  WIDTH  data selected when applied select = 1
//   sel         in  1      select request; 0 -> in_0, 1 -> in_1
//   out         out WIDTH  registered selected data
//   sel_q       out 1      select value applied to the current out
//   sel_switch  out 1      one-cycle pulse: sel_q changed on this edge
// Configuration:
//   MUX_2TO1_SEL_SYNC_EN  when defined, sel passes through a 2-flop
//     synchronizer first (sel-to-out latency 3 cycles, data latency stays 1).
//     When undefined, sel is used directly (latency 1). Ports are identical.
// ---------------------------------------------------------------------------
module mux_2to1
  import mux_2to1_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             sel_q,
  output logic             sel_switch
);

  mux_sel_e         sel_app;
  logic [WIDTH-1:0] out_q, out_d;
  logic             sel_d;
  logic             sel_switch_q, sel_switch_d;

`ifdef MUX_2TO1_SEL_SYNC_EN
  logic sel_sync;

  // sel may come from another domain; only the synchronized copy steers data.
  sync_2ff u_sel_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sel),
    .q     (sel_sync)
  );

  assign sel_app = mux_sel_e'(sel_sync);
`else
  assign sel_app = mux_sel_e'(sel);
`endif

  // Data and select are taken from the same edge, so a select change and a
  // data change in one cycle land together without mixing old and new values.
  always_comb begin
    out_d        = in_0;
    sel_d        = 1'b0;
    sel_switch_d = 1'b0;
    if (sel_app == SEL_IN1) begin
      out_d = in_1;
    end
    sel_d        = logic'(sel_app);
    sel_switch_d = (logic'(sel_app) != sel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      sel_q        <= 1'b0;
      sel_switch_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      sel_q        <= sel_d;
      sel_switch_q <= sel_switch_d;
    end
  end

  assign out        = out_q;
  assign sel_switch = sel_switch_q;

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// ---------------------------------------------------------------------------
// Testbench: tb_mux_2to1
// Purpose: self-checking bench for mux_2to1 (WIDTH=8). Inputs change 1 ns
//   after a rising edge; outputs are sampled 1 ns after the next rising edge.
//   Works in both builds; the select latency follows MUX_2TO1_SEL_SYNC_EN.
// ---------------------------------------------------------------------------
module tb_mux_2to1;

  localparam int W = 8;
`ifdef MUX_2TO1_SEL_SYNC_EN
  localparam int SEL_LAT = 3;
`else
  localparam int SEL_LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_0;
  logic [W-1:0] in_1;
  logic         sel;
  logic [W-1:0] out;
  logic         sel_q;
  logic         sel_switch;

  int checks   = 0;
  int failures = 0;

  // Reference model: the select requests seen on past edges wait in a queue
  // until they are old enough to be applied.
  logic         sel_pipe[$];
  logic         exp_sel;
  logic         exp_sw;
  logic [W-1:0] exp_out;

  typedef struct {
    logic         sel;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic [W-1:0] e_out;
    logic         e_sel;
    logic         e_sw;
  } vec_t;

  vec_t vecs[8];

  mux_2to1 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_0       (in_0),
    .in_1       (in_1),
    .sel        (sel),
    .out        (out),
    .sel_q      (sel_q),
    .sel_switch (sel_switch)
  );

  // 10 ns clock, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bound the whole run so a stuck simulation still ends with a verdict.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run still active at 200000 ns, required finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    sel_pipe.delete();
    for (int i = 0; i < SEL_LAT - 1; i++) sel_pipe.push_back(1'b0);
    exp_sel = 1'b0;
    exp_sw  = 1'b0;
    exp_out = '0;
  endtask

  // One rising edge as seen by the model, using the values driven before it.
  task automatic modelEdge(input logic s, input logic [W-1:0] d0, input logic [W-1:0] d1);
    logic applied;
    sel_pipe.push_back(s);
    applied = sel_pipe.pop_front();
    exp_sw  = (applied != exp_sel);
    exp_sel = applied;
    exp_out = applied ? d1 : d0;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] e_out,
                             input logic e_sel, input logic e_sw);
    checks += 3;
    if (out !== e_out) begin
      failures++;
      $display("[TB] FAIL %s out: got %h expected %h", name, out, e_out);
    end
    if (sel_q !== e_sel) begin
      failures++;
      $display("[TB] FAIL %s sel_q: got %b expected %b", name, sel_q, e_sel);
    end
    if (sel_switch !== e_sw) begin
      failures++;
      $display("[TB] FAIL %s sel_switch: got %b expected %b", name, sel_switch, e_sw);
    end
  endtask

  // Drive inputs, take one edge, update the model, sample 1 ns later.
  task automatic applyStimulus(input logic s, input logic [W-1:0] d0, input logic [W-1:0] d1);
    sel  = s;
    in_0 = d0;
    in_1 = d1;
    @(posedge clk);
    modelEdge(s, d0, d1);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    sel   = 1'b0;
    in_0  = '0;
    in_1  = '0;

    // Directed vectors for the unsynchronized build (1-cycle select latency).
    vecs[0] = '{1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h33, 8'h5A, 8'h5A, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 8'h77, 8'hA5, 8'hA5, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h3C, 8'hFF, 8'hFF, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 8'h12, 8'hFF, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h81, 8'hFE, 8'h81, 1'b0, 1'b1};

    // Reset asserted with no edge: outputs clear at once.
    #2;
    sel   = 1'b1;
    in_0  = '0;
    in_1  = 8'h01;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_async", '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_held", '0, 1'b0, 1'b0);

    // First edges after release with sel=1: switch lands after SEL_LAT edges.
    sel   = 1'b1;
    in_0  = 8'h00;
    in_1  = 8'h01;
    rst_n = 1'b1;
    for (int e = 1; e <= SEL_LAT + 1; e++) begin
      @(posedge clk);
      modelEdge(1'b1, 8'h00, 8'h01);
      #1;
      checkOutput($sformatf("first_edge_%0d", e), (e >= SEL_LAT) ? 8'h01 : 8'h00,
                  (e >= SEL_LAT), (e == SEL_LAT));
    end

    doReset();

    // Static select: five edges with sel=0.
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 8'h00, 8'h01);
      checkOutput($sformatf("static_%0d", c), 8'h00, 1'b0, 1'b0);
    end

`ifndef MUX_2TO1_SEL_SYNC_EN
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].in0, vecs[i].in1);
      checkOutput($sformatf("vec_%0d", i), vecs[i].e_out, vecs[i].e_sel, vecs[i].e_sw);
    end
`else
    // Synchronized build: a 0->1 request reaches sel_q exactly 3 edges later,
    // while data on the already-selected input keeps 1-cycle latency.
    applyStimulus(1'b0, 8'h11, 8'h22);
    checkOutput("sync_data", 8'h11, 1'b0, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      applyStimulus(1'b1, 8'h11, 8'hC3);
      checkOutput($sformatf("sync_lat_%0d", e), (e >= 3) ? 8'hC3 : 8'h11,
                  (e >= 3), (e == 3));
    end
`endif

    // Toggle sel every cycle for 100 ns with random data, checked by the model.
    for (int c = 0; c < 10; c++) begin
      applyStimulus(~sel, W'($urandom), W'($urandom));
      checkOutput($sformatf("toggle_%0d", c), exp_out, exp_sel, exp_sw);
    end

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      applyStimulus(1'($urandom), W'($urandom), W'($urandom));
      checkOutput($sformatf("rand_%0d", c), exp_out, exp_sel, exp_sw);
    end

    // Reset mid-operation with out and sel_q non-zero.
    for (int c = 0; c < SEL_LAT + 1; c++) begin
      applyStimulus(1'b1, 8'h0F, 8'hF0);
    end
    checkOutput("pre_reset", 8'hF0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_mid", '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_mid_held", '0, 1'b0, 1'b0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_2to1
